// File: rtl/res_cmd_sequencer.sv
// Resistor command sequencer: parses UART frames, shadows each code in RAM and optionally sends it over SPI.
// Optional RES_CMD_CHECKSUM_EN adds a third frame byte (byte0 ^ byte1) checked in a GET_CSUM state.
module res_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYC  = 1_000_000,
  parameter int unsigned SPI_ACK_CYC  = 16,
  parameter bit          REVERSE_BITS = 1'b1,
  parameter logic [3:0]  HDR_NIBBLE   = 4'hA
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       ram_cs,
  output logic       ram_rw,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_din,
  output logic [9:0] spi_data,
  output logic       spi_start,
  input  logic       spi_busy,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [7:0] err_cnt,
  output logic       busy
);

  localparam int unsigned TMR_MAX = (TIMEOUT_CYC > SPI_ACK_CYC) ? TIMEOUT_CYC : SPI_ACK_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] ACK_LAST = TMR_W'(SPI_ACK_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_GET_CODE  = 4'd1,
`ifdef RES_CMD_CHECKSUM_EN
    S_GET_CSUM  = 4'd2,
`endif
    S_RAM_WR    = 4'd3,
    S_SPI_START = 4'd4,
    S_SPI_ACK   = 4'd5,
    S_SPI_WAIT  = 4'd6,
    S_DONE      = 4'd7,
    S_ERR       = 4'd8
  } state_t;

  state_t           state, state_n;
  logic [7:0]       rx_byte;
  logic             hdr_bad;
  logic [1:0]       ch_q;
  logic             apply_q;
  logic [7:0]       code_q;
  logic [7:0]       wr_code;
  logic [TMR_W-1:0] tmr;
  logic             timed_state;
  logic             drop_byte;
`ifdef RES_CMD_CHECKSUM_EN
  logic [7:0]       hdr_q;
  logic             csum_ok;
`endif

  always_comb begin
    rx_byte = rx_data;
    if (REVERSE_BITS) begin
      for (int unsigned i = 0; i < 8; i++) begin
        rx_byte[i] = rx_data[3'(7 - i)];
      end
    end
  end

  assign hdr_bad = (rx_byte[7:4] != HDR_NIBBLE) || rx_byte[3];

`ifdef RES_CMD_CHECKSUM_EN
  assign csum_ok = (rx_byte == (hdr_q ^ code_q));
  assign wr_code = code_q;
`else
  // Without a checksum the write is entered on the code strobe itself, before code_q is loaded.
  assign wr_code = (state == S_GET_CODE) ? rx_byte : code_q;
`endif

  assign timed_state = (state == S_GET_CODE) || (state == S_SPI_ACK)
`ifdef RES_CMD_CHECKSUM_EN
                    || (state == S_GET_CSUM)
`endif
                    ;

  assign drop_byte = rx_valid && (state inside {S_RAM_WR, S_SPI_START, S_SPI_ACK,
                                                S_SPI_WAIT, S_DONE, S_ERR});

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (rx_valid) state_n = hdr_bad ? S_ERR : S_GET_CODE;
      end
      S_GET_CODE: begin
`ifdef RES_CMD_CHECKSUM_EN
        if (rx_valid)             state_n = S_GET_CSUM;
`else
        if (rx_valid)             state_n = S_RAM_WR;
`endif
        else if (tmr == TMO_LAST) state_n = S_ERR;
      end
`ifdef RES_CMD_CHECKSUM_EN
      S_GET_CSUM: begin
        if (rx_valid)             state_n = csum_ok ? S_RAM_WR : S_ERR;
        else if (tmr == TMO_LAST) state_n = S_ERR;
      end
`endif
      S_RAM_WR:    state_n = apply_q ? S_SPI_START : S_DONE;
      S_SPI_START: state_n = S_SPI_ACK;
      S_SPI_ACK: begin
        if (spi_busy)             state_n = S_SPI_WAIT;
        else if (tmr == ACK_LAST) state_n = S_ERR;
      end
      S_SPI_WAIT: begin
        if (!spi_busy) state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      S_ERR:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    ram_cs    = 1'b1;
    ram_rw    = 1'b0;
    spi_start = 1'b0;
    frame_ok  = 1'b0;
    frame_err = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_RAM_WR: begin
        ram_cs = 1'b0;
        ram_rw = 1'b1;
      end
      S_SPI_START: spi_start = 1'b1;
      S_DONE:      frame_ok  = 1'b1;
      S_ERR:       frame_err = 1'b1;
      default: ;
    endcase
  end

  // Timer restarts on every state change, so each byte or ack wait gets its own window.
  always_ff @(posedge clk) begin
    if (!reset)                tmr <= '0;
    else if (state_n != state) tmr <= '0;
    else if (timed_state)      tmr <= tmr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ch_q    <= '0;
      apply_q <= 1'b0;
      code_q  <= '0;
`ifdef RES_CMD_CHECKSUM_EN
      hdr_q   <= '0;
`endif
    end else begin
      if ((state == S_IDLE) && rx_valid && !hdr_bad) begin
        ch_q    <= rx_byte[1:0];
        apply_q <= rx_byte[2];
`ifdef RES_CMD_CHECKSUM_EN
        hdr_q   <= rx_byte;
`endif
      end
      if ((state == S_GET_CODE) && rx_valid) code_q <= rx_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ram_addr <= '0;
      ram_din  <= '0;
      spi_data <= '0;
    end else begin
      if ((state_n == S_RAM_WR) && (state != S_RAM_WR)) begin
        ram_addr <= {6'b0, ch_q};
        ram_din  <= wr_code;
      end
      if (state_n == S_SPI_START) spi_data <= {ch_q, code_q};
    end
  end

  // A frame error and a dropped byte in the same cycle count once.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_cnt <= '0;
    end else if (((state == S_ERR) || drop_byte) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
